// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: state encodings and stage-control bundle shared by the hazard sequencer.
`default_nettype none

package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwr_bubble;
  } stage_ctrl_t;

  function automatic stage_ctrl_t ctrl_free();
    stage_ctrl_t c;
    c.pc_en        = 1'b1;
    c.ifid_en      = 1'b1;
    c.idex_en      = 1'b1;
    c.exmem_en     = 1'b1;
    c.ifid_flush   = 1'b0;
    c.idex_flush   = 1'b0;
    c.memwr_bubble = 1'b0;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_lu_detect.sv
// pipe_lu_detect: combinational load-use compare between the load in EX and the sources read in ID.
`default_nettype none

module pipe_lu_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rw,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       lu
);

  // $0 is hardwired, so a load targeting it can never feed a dependent instruction.
  assign lu = ex_mem_read && (ex_rw != 5'd0) &&
              ((ex_rw == id_rs) || (id_uses_rt && (ex_rw == id_rt)));

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with a data-memory wait watchdog.
// Optional macro PIPE_PERF_EN adds the perf_stall / perf_flush cycle counters.
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_uses_rt,
  input  logic       ID_jump,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_Rw,
  input  logic       EX_branch_taken,
  input  logic       MEM_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       IFID_en,
  output logic       IDEX_en,
  output logic       EXMEM_en,
  output logic       IFID_flush,
  output logic       IDEX_flush,
  output logic       MEMWR_bubble,
  output logic       mem_err
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam bit               NO_WAIT  = (MEM_TIMEOUT == 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic        lu;
  logic        mem_pending;
  logic        timeout;
  logic        mstall;
  logic        redirect_flush;
  stage_ctrl_t ctrl;

  pipe_lu_detect u_lu_detect (
    .ex_mem_read (EX_MemRead),
    .ex_rw       (EX_Rw),
    .id_rs       (ID_rs),
    .id_rt       (ID_rt),
    .id_uses_rt  (ID_uses_rt),
    .lu          (lu)
  );

  assign mem_pending = MEM_req && !mem_ready;

  // With a one-cycle budget the very first miss is already the last allowed cycle.
  assign timeout = mem_pending &&
                   (((state_q == ST_MEMWAIT) && (wait_cnt_q == LAST_CNT)) ||
                    (NO_WAIT && (state_q == ST_RUN)));

  assign mstall = mem_pending && !timeout;

  always_comb begin
    ctrl           = ctrl_free();
    redirect_flush = 1'b0;
    if (rst) begin
      ctrl.pc_en        = 1'b0;
      ctrl.ifid_en      = 1'b0;
      ctrl.idex_en      = 1'b0;
      ctrl.exmem_en     = 1'b0;
      ctrl.ifid_flush   = 1'b1;
      ctrl.idex_flush   = 1'b1;
      ctrl.memwr_bubble = 1'b1;
    end else if (mstall) begin
      // EX and ID stay frozen, so a pending branch/jump is simply re-seen on release.
      ctrl.pc_en        = 1'b0;
      ctrl.ifid_en      = 1'b0;
      ctrl.idex_en      = 1'b0;
      ctrl.exmem_en     = 1'b0;
      ctrl.memwr_bubble = 1'b1;
    end else if (EX_branch_taken) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
      redirect_flush  = 1'b1;
    end else if (lu) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_en    = 1'b0;
      ctrl.idex_flush = 1'b1;
    end else if (ID_jump) begin
      ctrl.ifid_flush = 1'b1;
      redirect_flush  = 1'b1;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign IFID_en      = ctrl.ifid_en;
  assign IDEX_en      = ctrl.idex_en;
  assign EXMEM_en     = ctrl.exmem_en;
  assign IFID_flush   = ctrl.ifid_flush;
  assign IDEX_flush   = ctrl.idex_flush;
  assign MEMWR_bubble = ctrl.memwr_bubble;
  assign mem_err      = mem_err_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (mem_pending) begin
          if (timeout) begin
            mem_err_d = 1'b1;
          end else begin
            state_d    = ST_MEMWAIT;
            wait_cnt_d = ONE_CNT;
          end
        end
      end
      ST_MEMWAIT: begin
        if (!mem_pending) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (timeout) begin
          // Stale MEM result is let through; the fault is only reported.
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + ONE_CNT;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (mstall || lu) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (redirect_flush) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect_flush;
`endif

endmodule

`default_nettype wire
